// File: rtl/uart_mmio_initiator.sv
// Bus initiator that polls a UART status register and moves bytes between client
// valid/ready streams and the UART TX/RX data registers. Optional TX timeout: UART_INIT_TIMEOUT_EN.
module uart_mmio_initiator #(
   parameter logic [31:0] STATUS_ADDR   = 32'h8,
   parameter logic [31:0] TX_ADDR       = 32'h0,
   parameter logic [31:0] RX_ADDR       = 32'h4,
   parameter int          POLL_GAP      = 2,
   parameter int          TIMEOUT_POLLS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  tx_byte,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [7:0]  rx_byte,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic [31:0] addr,
   output logic [7:0]  write_data,
   output logic        write_enable,
   output logic        read_enable,
   input  logic [7:0]  read_data,
   output logic        err
);

   localparam int               GAP_W    = (POLL_GAP < 1) ? 1 : $clog2(POLL_GAP + 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP);

   if (POLL_GAP < 1 || TIMEOUT_POLLS < 1) begin : g_cfg_check
      $error("uart_mmio_initiator: POLL_GAP and TIMEOUT_POLLS must be >= 1");
   end

   typedef enum logic [2:0] {
      S_GAP,
      S_POLL_RD,
      S_POLL_WAIT,
      S_TX_WR,
      S_RX_RD,
      S_RX_WAIT,
      S_RX_HOLD,
      S_DROP
   } state_t;

   state_t           state_reg, state_next;
   logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
   logic [31:0]      addr_reg, addr_next;
   logic [7:0]       write_data_reg, write_data_next;
   logic [7:0]       rx_byte_reg, rx_byte_next;
   logic             write_enable_reg, write_enable_next;
   logic             read_enable_reg, read_enable_next;
   logic             tx_ready_reg, tx_ready_next;
   logic             rx_valid_reg, rx_valid_next;

`ifdef UART_INIT_TIMEOUT_EN
   localparam int              TO_W    = $clog2(TIMEOUT_POLLS + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_POLLS);

   logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
   logic            err_reg, err_next;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg        <= S_GAP;
         gap_cnt_reg      <= '0;
         addr_reg         <= '0;
         write_data_reg   <= '0;
         rx_byte_reg      <= '0;
         write_enable_reg <= 1'b0;
         read_enable_reg  <= 1'b0;
         tx_ready_reg     <= 1'b0;
         rx_valid_reg     <= 1'b0;
`ifdef UART_INIT_TIMEOUT_EN
         to_cnt_reg       <= '0;
         err_reg          <= 1'b0;
`endif
      end else begin
         state_reg        <= state_next;
         gap_cnt_reg      <= gap_cnt_next;
         addr_reg         <= addr_next;
         write_data_reg   <= write_data_next;
         rx_byte_reg      <= rx_byte_next;
         write_enable_reg <= write_enable_next;
         read_enable_reg  <= read_enable_next;
         tx_ready_reg     <= tx_ready_next;
         rx_valid_reg     <= rx_valid_next;
`ifdef UART_INIT_TIMEOUT_EN
         to_cnt_reg       <= to_cnt_next;
         err_reg          <= err_next;
`endif
      end
   end

   // Next-state decision first, then the registered outputs are derived from the
   // state being entered so every strobe lines up with its state's cycle.
   always_comb begin
      state_next        = state_reg;
      gap_cnt_next      = gap_cnt_reg;
      addr_next         = addr_reg;
      write_data_next   = write_data_reg;
      rx_byte_next      = rx_byte_reg;
      write_enable_next = 1'b0;
      read_enable_next  = 1'b0;
      tx_ready_next     = 1'b0;
      rx_valid_next     = rx_valid_reg;
`ifdef UART_INIT_TIMEOUT_EN
      to_cnt_next       = to_cnt_reg;
      err_next          = err_reg;
`endif

      case (state_reg)
         S_GAP: begin
            if (gap_cnt_reg + GAP_W'(1) == GAP_LAST) begin
               gap_cnt_next = '0;
               state_next   = S_POLL_RD;
            end else begin
               gap_cnt_next = gap_cnt_reg + GAP_W'(1);
            end
         end
         S_POLL_RD: state_next = S_POLL_WAIT;
         S_POLL_WAIT: begin
            // read_data holds the status word this cycle; RX wins to avoid overrun.
`ifdef UART_INIT_TIMEOUT_EN
            to_cnt_next = '0;
`endif
            if (read_data[1]) begin
               state_next = S_RX_RD;
            end else if (tx_valid && !read_data[0]) begin
               state_next = S_TX_WR;
`ifdef UART_INIT_TIMEOUT_EN
            end else if (tx_valid && (to_cnt_reg + TO_W'(1) == TO_LAST)) begin
               state_next = S_DROP;
            end else if (tx_valid) begin
               to_cnt_next = to_cnt_reg + TO_W'(1);
               state_next  = S_GAP;
`endif
            end else begin
               state_next = S_GAP;
            end
         end
         S_TX_WR: state_next = S_GAP;
         S_RX_RD: state_next = S_RX_WAIT;
         S_RX_WAIT: begin
            rx_byte_next  = read_data;
            rx_valid_next = 1'b1;
            state_next    = S_RX_HOLD;
         end
         S_RX_HOLD: begin
            if (rx_valid_reg && rx_ready) begin
               rx_valid_next = 1'b0;
               state_next    = S_GAP;
            end
         end
         S_DROP:  state_next = S_GAP;
         default: state_next = S_GAP;
      endcase

      case (state_next)
         S_POLL_RD: begin
            read_enable_next = 1'b1;
            addr_next        = STATUS_ADDR;
         end
         S_RX_RD: begin
            read_enable_next = 1'b1;
            addr_next        = RX_ADDR;
         end
         S_TX_WR: begin
            write_enable_next = 1'b1;
            addr_next         = TX_ADDR;
            write_data_next   = tx_byte;
            tx_ready_next     = 1'b1;
         end
         S_DROP: begin
            // Byte is consumed but never written; err stays set until reset.
            tx_ready_next = 1'b1;
`ifdef UART_INIT_TIMEOUT_EN
            err_next      = 1'b1;
`endif
         end
         default: ;
      endcase
   end

   assign addr         = addr_reg;
   assign write_data   = write_data_reg;
   assign write_enable = write_enable_reg;
   assign read_enable  = read_enable_reg;
   assign tx_ready     = tx_ready_reg;
   assign rx_byte      = rx_byte_reg;
   assign rx_valid     = rx_valid_reg;

`ifdef UART_INIT_TIMEOUT_EN
   assign err = err_reg;
`else
   assign err = 1'b0;
`endif

endmodule
